wb_ctrl: RTL and testbench
==========================

Name: wb_ctrl

Overview:
- Write-side controller for the 32x32 integer register file: the single writer that drives the file's write enable, write address and write data.
- Merges two result sources:
  - ex results: single-cycle, not buffered.
  - lsu results: long-latency loads, buffered in a small FIFO.
- Keeps a per-register busy scoreboard of outstanding long-latency destinations; id uses it to stall dependent reads.
- Sits between ex/lsu and regs; id reads the busy flags.

Parameters:
- REG_NUM, 32, number of architectural registers.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- FIFO_DEPTH, 4, lsu result buffer entries; must be a power of two, at least 2.

Ports:
- i_Clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_ex_we  input  1  ex result valid this cycle.
- i_ex_waddr  input  ADDR_W  ex destination register.
- i_ex_wdata  input  DATA_W  ex result.
- o_ex_stall  output  1  ex write not accepted this cycle; ex holds its result.
- i_lsu_valid  input  1  lsu result valid.
- o_lsu_ready  output  1  FIFO can accept an lsu result.
- i_lsu_waddr  input  ADDR_W  lsu destination register.
- i_lsu_wdata  input  DATA_W  lsu result.
- i_issue_valid  input  1  long-latency op issued by id.
- i_issue_addr  input  ADDR_W  destination register of the issued op.
- i_chk_addr1  input  ADDR_W  id source address 1.
- i_chk_addr2  input  ADDR_W  id source address 2.
- o_busy1  output  1  source 1 has an outstanding write.
- o_busy2  output  1  source 2 has an outstanding write.
- o_we  output  1  write enable to regs.
- o_w_addr  output  ADDR_W  write address to regs.
- o_w_data  output  DATA_W  write data to regs.

Behaviour:
- Reset: o_we=0, o_w_addr=0, o_w_data=0; FIFO empty (count=0, pointers=0); busy vector all zero.
  - o_lsu_ready=0 and o_ex_stall=0 while i_reset is high.
  - Reset mid-operation discards FIFO contents and the busy vector.
- lsu FIFO:
  - Push on i_lsu_valid && o_lsu_ready; o_lsu_ready = !full.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - lsu results with address 0 are accepted and dropped: not pushed, no busy change.
- Write-port arbitration, evaluated each cycle on registered FIFO state:
  - count==FIFO_DEPTH: FIFO head wins. o_ex_stall=1 if i_ex_we; the ex write is not taken and ex must re-present it.
  - Otherwise, i_ex_we && i_ex_waddr!=0: ex wins; FIFO not popped; o_ex_stall=0.
  - Otherwise, FIFO not empty: pop the head.
  - Otherwise: o_we=0 next cycle.
  - ex writes to address 0 are consumed with no write and no stall.
- Output registers:
  - Selected write appears on o_we/o_w_addr/o_w_data one cycle after selection.
  - o_we is a single-cycle pulse per write.
  - o_w_addr/o_w_data hold their last values when o_we=0.
- Latency:
  - ex result presented in cycle N -> o_we in N+1.
  - lsu result pushed in cycle N -> earliest pop in N+1 -> o_we in N+2. No FIFO bypass.
- Scoreboard:
  - busy[a] set on i_issue_valid with a!=0.
  - busy[a] cleared in the cycle a FIFO-sourced write to a is selected.
  - Set and clear of the same address in one cycle: set wins.
  - ex writes never change busy.
  - Issue to an address already busy is illegal; id prevents it using o_busy1/o_busy2. Verification flags it as an assertion failure.
- Busy outputs (combinational):
  - o_busyK = busy[i_chk_addrK] && i_chk_addrK!=0.
  - Does not reflect a clear occurring in the same cycle. Forwarding of the write itself is done inside regs.
- Ordering: FIFO pops in push order; lsu results reach regs in arrival order.

Decomposition:
- Shared defines header, already included project-wide: RegsAddrBus, RegsDataBus, RegsNum, Reg0Addr, ZeroWord, WriteEnable/WriteDisable, ResetEnable/ResetDisable.
- Add to the same header: WbFifoDepth and ScoreboardBus.
- One sub-module: wb_fifo, a synchronous FIFO.
  - Ports: clk, reset, push, pop, din, dout, full, empty.
  - Parameterised by data width ADDR_W+DATA_W and depth.
- Scoreboard and arbitration stay in wb_ctrl.

Test Plan:
- ex only: i_ex_we=1, waddr=5, wdata=0x12345678 in cycle 0 -> o_we=1, o_w_addr=5, o_w_data=0x12345678 in cycle 1; o_we=0 in cycle 2.
- Scoreboard round trip: issue addr=7 in cycle 0 -> o_busy1=1 with chk_addr1=7 from cycle 1; lsu push (7, 0xDEADBEEF) in cycle 3 -> o_we to x7 in cycle 5; o_busy1=0 from cycle 5.
- Contention: FIFO holds 1 entry and ex writes x3 in the same cycle -> ex written first (next cycle), FIFO entry written the following cycle; no o_ex_stall.
- Full FIFO: push 4 lsu results while ex writes continuously -> o_lsu_ready=0 and count=4; when ex asserts, o_ex_stall=1, head entry written; ex write retired after stall drops.
- x0 handling: ex write x0=0xFFFFFFFF, lsu push x0, issue x0 -> o_we never asserted, busy unchanged, o_busy1=0 for chk_addr1=0.
- Reset mid-operation: 3 entries queued and busy[9]=1, assert i_reset one cycle -> o_we=0, o_lsu_ready=0 during reset, FIFO empty and o_busy=0 after; no stale write appears.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// Shared register-file bus types and constants for the write-back controller.
package wb_ctrl_pkg;

  localparam int REG_NUM    = 32;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  localparam int RegsNum     = REG_NUM;
  localparam int WbFifoDepth = FIFO_DEPTH;

  typedef logic [ADDR_W-1:0]  RegsAddrBus;
  typedef logic [DATA_W-1:0]  RegsDataBus;
  typedef logic [REG_NUM-1:0] ScoreboardBus;

  localparam RegsAddrBus Reg0Addr     = '0;
  localparam RegsDataBus ZeroWord     = '0;
  localparam logic       WriteEnable  = 1'b1;
  localparam logic       WriteDisable = 1'b0;
  localparam logic       ResetEnable  = 1'b1;
  localparam logic       ResetDisable = 1'b0;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency load results; head is readable
// combinationally so a pop can feed the write-port register in the same cycle.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  import wb_ctrl_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset == ResetEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_ctrl.sv
// Single writer into the integer register file: arbitrates ex results against
// buffered lsu results and tracks outstanding long-latency destinations.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int REG_NUM    = RegsNum,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = WbFifoDepth
) (
  input  logic              i_Clk,
  input  logic              i_reset,
  input  logic              i_ex_we,
  input  logic [ADDR_W-1:0] i_ex_waddr,
  input  logic [DATA_W-1:0] i_ex_wdata,
  output logic              o_ex_stall,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic [ADDR_W-1:0] i_lsu_waddr,
  input  logic [DATA_W-1:0] i_lsu_wdata,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_addr,
  input  logic [ADDR_W-1:0] i_chk_addr1,
  input  logic [ADDR_W-1:0] i_chk_addr2,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic [DATA_W-1:0] o_w_data
);

  logic [ADDR_W+DATA_W-1:0] fifo_dout;
  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;

  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
  logic [DATA_W-1:0]  w_data_q, w_data_d;

  wb_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (i_Clk),
    .reset(i_reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  ({i_lsu_waddr, i_lsu_wdata}),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign head_addr = fifo_dout[DATA_W +: ADDR_W];
  assign head_data = fifo_dout[DATA_W-1:0];

  // Loads targeting x0 are acknowledged but never enter the buffer.
  assign o_lsu_ready = !i_reset && !fifo_full;
  assign fifo_push   = i_lsu_valid && o_lsu_ready && (i_lsu_waddr != '0);

  always_comb begin
    fifo_pop   = 1'b0;
    o_ex_stall = 1'b0;
    we_d       = WriteDisable;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    if (!i_reset) begin
      // A full buffer takes priority so ex cannot starve the load path.
      if (fifo_full) begin
        fifo_pop   = 1'b1;
        o_ex_stall = i_ex_we;
        we_d       = WriteEnable;
        w_addr_d   = head_addr;
        w_data_d   = head_data;
      end else if (i_ex_we && (i_ex_waddr != '0)) begin
        we_d     = WriteEnable;
        w_addr_d = i_ex_waddr;
        w_data_d = i_ex_wdata;
      end else if (!fifo_empty) begin
        fifo_pop = 1'b1;
        we_d     = WriteEnable;
        w_addr_d = head_addr;
        w_data_d = head_data;
      end
    end
  end

  // Clear before set so a same-cycle re-issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[head_addr] = 1'b0;
    if (i_issue_valid && (i_issue_addr != '0)) busy_d[i_issue_addr] = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_reset == ResetEnable) begin
      busy_q   <= '0;
      we_q     <= WriteDisable;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      busy_q   <= busy_d;
      we_q     <= we_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign o_busy1  = busy_q[i_chk_addr1] && (i_chk_addr1 != '0);
  assign o_busy2  = busy_q[i_chk_addr2] && (i_chk_addr2 != '0);
  assign o_we     = we_q;
  assign o_w_addr = w_addr_q;
  assign o_w_data = w_data_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Scenario bench for wb_ctrl: expected register writes are queued as stimulus
// is driven and matched by a monitor as they appear on the write port.
module tb_wb_ctrl;

  logic        i_Clk = 1'b0;
  logic        i_reset;
  logic        i_ex_we;
  logic [4:0]  i_ex_waddr;
  logic [31:0] i_ex_wdata;
  logic        o_ex_stall;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_waddr;
  logic [31:0] i_lsu_wdata;
  logic        i_issue_valid;
  logic [4:0]  i_issue_addr;
  logic [4:0]  i_chk_addr1;
  logic [4:0]  i_chk_addr2;
  logic        o_busy1;
  logic        o_busy2;
  logic        o_we;
  logic [4:0]  o_w_addr;
  logic [31:0] o_w_data;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 i_Clk = ~i_Clk;

  wb_ctrl dut (
    .i_Clk        (i_Clk),
    .i_reset      (i_reset),
    .i_ex_we      (i_ex_we),
    .i_ex_waddr   (i_ex_waddr),
    .i_ex_wdata   (i_ex_wdata),
    .o_ex_stall   (o_ex_stall),
    .i_lsu_valid  (i_lsu_valid),
    .o_lsu_ready  (o_lsu_ready),
    .i_lsu_waddr  (i_lsu_waddr),
    .i_lsu_wdata  (i_lsu_wdata),
    .i_issue_valid(i_issue_valid),
    .i_issue_addr (i_issue_addr),
    .i_chk_addr1  (i_chk_addr1),
    .i_chk_addr2  (i_chk_addr2),
    .o_busy1      (o_busy1),
    .o_busy2      (o_busy2),
    .o_we         (o_we),
    .o_w_addr     (o_w_addr),
    .o_w_data     (o_w_data)
  );

  // Write-port monitor: every write must match the oldest expectation.
  always @(negedge i_Clk) begin
    exp_t e;
    if (o_we === 1'b1) begin
      $display("write x%0d = %h", o_w_addr, o_w_data);
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got x%0d=%h, required no write", o_w_addr, o_w_data);
      end else begin
        e = sb.pop_front();
        if ({o_w_addr, o_w_data} !== {e.a, e.d})
          $display("FAIL sb_write: got x%0d=%h, required x%0d=%h", o_w_addr, o_w_data, e.a, e.d);
        else
          passed++;
      end
    end
  end

  // Issuing to a register that is still outstanding is a protocol violation.
  always @(posedge i_Clk) begin
    if (!i_reset && i_issue_valid && i_issue_addr != 5'd0)
      assert (!dut.busy_q[i_issue_addr])
      else $error("issue to busy register x%0d", i_issue_addr);
  end

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_Clk);
  endtask

  task automatic idle();
    i_ex_we       = 1'b0;
    i_ex_waddr    = '0;
    i_ex_wdata    = '0;
    i_lsu_valid   = 1'b0;
    i_lsu_waddr   = '0;
    i_lsu_wdata   = '0;
    i_issue_valid = 1'b0;
    i_issue_addr  = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      step();
      n++;
    end
    step();
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    idle();
    i_chk_addr1 = 5'd5;
    i_chk_addr2 = 5'd6;
    repeat (2) step();
    mid();
    checks++;
    if ({o_we, o_w_addr, o_w_data} !== 38'd0)
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h, required 0/0/0", o_we, o_w_addr, o_w_data);
    else passed++;
    checks++;
    if ({o_lsu_ready, o_ex_stall} !== 2'b00)
      $display("FAIL reset_handshake: got ready=%b stall=%b, required 0/0", o_lsu_ready, o_ex_stall);
    else passed++;
    step();
    i_reset = 1'b0;
    mid();
    checks++;
    if ({o_lsu_ready, o_busy1, o_busy2} !== 3'b100)
      $display("FAIL post_reset: got ready=%b busy1=%b busy2=%b, required 1/0/0", o_lsu_ready, o_busy1, o_busy2);
    else passed++;
  endtask

  task automatic test_ex_only();
    step();
    i_ex_we = 1'b1; i_ex_waddr = 5'd5; i_ex_wdata = 32'h12345678;
    sb.push_back('{5'd5, 32'h12345678});
    mid();
    checks++;
    if (o_ex_stall !== 1'b0) $display("FAIL ex_stall: got %b, required 0", o_ex_stall);
    else passed++;
    step();
    idle();
    mid();
    checks++;
    if ({o_we, o_w_addr, o_w_data} !== {1'b1, 5'd5, 32'h12345678})
      $display("FAIL ex_latency: got we=%b x%0d=%h, required 1 x5=12345678", o_we, o_w_addr, o_w_data);
    else passed++;
    step();
    mid();
    checks++;
    if ({o_we, o_w_addr, o_w_data} !== {1'b0, 5'd5, 32'h12345678})
      $display("FAIL ex_pulse_hold: got we=%b x%0d=%h, required 0 x5=12345678", o_we, o_w_addr, o_w_data);
    else passed++;
    drain();
    checks++;
    if (sb.size() != 0) $display("FAIL ex_drain: got %0d pending, required 0", sb.size());
    else passed++;
  endtask

  task automatic test_scoreboard();
    step();
    i_issue_valid = 1'b1; i_issue_addr = 5'd7;
    i_chk_addr1 = 5'd7; i_chk_addr2 = 5'd7;
    mid();
    checks++;
    if (o_busy1 !== 1'b0) $display("FAIL sb_busy_c0: got %b, required 0", o_busy1);
    else passed++;
    step();
    idle();
    mid();
    checks++;
    if ({o_busy1, o_busy2} !== 2'b11) $display("FAIL sb_busy_c1: got %b%b, required 11", o_busy1, o_busy2);
    else passed++;
    step();
    step();
    i_lsu_valid = 1'b1; i_lsu_waddr = 5'd7; i_lsu_wdata = 32'hDEADBEEF;
    sb.push_back('{5'd7, 32'hDEADBEEF});
    mid();
    checks++;
    if ({o_lsu_ready, o_busy1} !== 2'b11) $display("FAIL sb_push_c3: got ready=%b busy1=%b, required 1/1", o_lsu_ready, o_busy1);
    else passed++;
    step();
    idle();
    mid();
    checks++;
    if ({o_we, o_busy1} !== 2'b01) $display("FAIL sb_no_bypass_c4: got we=%b busy1=%b, required 0/1", o_we, o_busy1);
    else passed++;
    step();
    mid();
    checks++;
    if ({o_we, o_w_addr, o_busy1, o_busy2} !== {1'b1, 5'd7, 2'b00})
      $display("FAIL sb_clear_c5: got we=%b x%0d busy=%b%b, required 1 x7 00", o_we, o_w_addr, o_busy1, o_busy2);
    else passed++;
    drain();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    else passed++;
  endtask

  task automatic test_contention();
    step();
    i_lsu_valid = 1'b1; i_lsu_waddr = 5'd10; i_lsu_wdata = 32'hA5A5A5A5;
    step();
    idle();
    i_ex_we = 1'b1; i_ex_waddr = 5'd3; i_ex_wdata = 32'h0000BEEF;
    sb.push_back('{5'd3, 32'h0000BEEF});
    mid();
    checks++;
    if (o_ex_stall !== 1'b0) $display("FAIL cont_stall: got %b, required 0", o_ex_stall);
    else passed++;
    step();
    idle();
    sb.push_back('{5'd10, 32'hA5A5A5A5});
    mid();
    checks++;
    if ({o_we, o_w_addr} !== {1'b1, 5'd3}) $display("FAIL cont_ex_first: got we=%b x%0d, required 1 x3", o_we, o_w_addr);
    else passed++;
    step();
    mid();
    checks++;
    if ({o_we, o_w_addr} !== {1'b1, 5'd10}) $display("FAIL cont_lsu_second: got we=%b x%0d, required 1 x10", o_we, o_w_addr);
    else passed++;
    drain();
    checks++;
    if (sb.size() != 0) $display("FAIL cont_drain: got %0d pending, required 0", sb.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t lsu [4];
    for (int i = 0; i < 4; i++) begin
      step();
      lsu[i] = '{5'(11 + i), 32'h1000 + 32'(i)};
      i_ex_we = 1'b1; i_ex_waddr = 5'(20 + i); i_ex_wdata = 32'(i);
      i_lsu_valid = 1'b1; i_lsu_waddr = lsu[i].a; i_lsu_wdata = lsu[i].d;
      sb.push_back('{5'(20 + i), 32'(i)});
      mid();
      checks++;
      if ({o_lsu_ready, o_ex_stall} !== 2'b10)
        $display("FAIL b2b_fill%0d: got ready=%b stall=%b, required 1/0", i, o_lsu_ready, o_ex_stall);
      else passed++;
    end
    step();
    i_ex_waddr = 5'd25; i_ex_wdata = 32'h25;
    i_lsu_waddr = 5'd15; i_lsu_wdata = 32'hBAD;
    sb.push_back(lsu[0]);
    mid();
    checks++;
    if ({o_lsu_ready, o_ex_stall} !== 2'b01)
      $display("FAIL b2b_full: got ready=%b stall=%b, required 0/1", o_lsu_ready, o_ex_stall);
    else passed++;
    step();
    i_lsu_valid = 1'b0;
    sb.push_back('{5'd25, 32'h25});
    mid();
    checks++;
    if ({o_lsu_ready, o_ex_stall} !== 2'b10)
      $display("FAIL b2b_retire: got ready=%b stall=%b, required 1/0", o_lsu_ready, o_ex_stall);
    else passed++;
    for (int i = 1; i < 4; i++) begin
      step();
      idle();
      sb.push_back(lsu[i]);
    end
    drain();
    checks++;
    if (sb.size() != 0) $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
    else passed++;
  endtask

  task automatic test_x0();
    step();
    i_ex_we = 1'b1; i_ex_waddr = 5'd0; i_ex_wdata = 32'hFFFFFFFF;
    i_lsu_valid = 1'b1; i_lsu_waddr = 5'd0; i_lsu_wdata = 32'h77;
    i_issue_valid = 1'b1; i_issue_addr = 5'd0;
    i_chk_addr1 = 5'd0;
    mid();
    checks++;
    if ({o_ex_stall, o_lsu_ready} !== 2'b01) $display("FAIL x0_handshake: got stall=%b ready=%b, required 0/1", o_ex_stall, o_lsu_ready);
    else passed++;
    step();
    idle();
    mid();
    checks++;
    if ({o_we, o_busy1} !== 2'b00) $display("FAIL x0_c1: got we=%b busy1=%b, required 0/0", o_we, o_busy1);
    else passed++;
    step();
    mid();
    checks++;
    if ({o_we, o_w_addr} !== {1'b0, 5'd14}) $display("FAIL x0_c2: got we=%b x%0d, required 0 x14", o_we, o_w_addr);
    else passed++;
  endtask

  task automatic test_reset_mid();
    step();
    i_issue_valid = 1'b1; i_issue_addr = 5'd9;
    i_chk_addr1 = 5'd9;
    for (int i = 1; i <= 3; i++) begin
      step();
      i_issue_valid = 1'b0;
      i_ex_we = 1'b1; i_ex_waddr = 5'(16 + i); i_ex_wdata = 32'hC0 + 32'(i);
      i_lsu_valid = 1'b1; i_lsu_waddr = 5'(26 + i); i_lsu_wdata = 32'hD0 + 32'(i);
      sb.push_back('{5'(16 + i), 32'hC0 + 32'(i)});
    end
    mid();
    checks++;
    if (o_busy1 !== 1'b1) $display("FAIL rst_pre_busy: got %b, required 1", o_busy1);
    else passed++;
    step();
    i_reset = 1'b1;
    i_ex_waddr = 5'd30; i_ex_wdata = 32'hE0;
    i_lsu_waddr = 5'd31; i_lsu_wdata = 32'hE1;
    mid();
    checks++;
    if ({o_lsu_ready, o_ex_stall} !== 2'b00) $display("FAIL rst_during: got ready=%b stall=%b, required 0/0", o_lsu_ready, o_ex_stall);
    else passed++;
    step();
    i_reset = 1'b0;
    idle();
    mid();
    checks++;
    if ({o_we, o_w_addr, o_busy1, o_lsu_ready} !== {1'b0, 5'd0, 2'b01})
      $display("FAIL rst_after: got we=%b x%0d busy1=%b ready=%b, required 0 x0 0 1", o_we, o_w_addr, o_busy1, o_lsu_ready);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      mid();
      checks++;
      if (o_we !== 1'b0) $display("FAIL rst_stale%0d: got we=%b x%0d, required 0", i, o_we, o_w_addr);
      else passed++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL rst_drain: got %0d pending, required 0", sb.size());
    else passed++;
  endtask

  initial begin
    i_reset = 1'b1;
    idle();
    i_chk_addr1 = '0;
    i_chk_addr2 = '0;
    test_reset();
    test_ex_only();
    test_scoreboard();
    test_contention();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required finish within 200000");
    $fatal(1, "timeout");
  end

endmodule
